// File: rtl/vu_pkg.sv
// Shared definitions for the VU meter byte-frame path: sync marker, frame layout,
// parser state encoding and the level-pair holding payload.
package vu_pkg;

    localparam int unsigned LEVEL_W   = 8;
    localparam int unsigned FRAME_LEN = 4;
    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        GET_L   = 2'd1,
        GET_R   = 2'd2,
        GET_CHK = 2'd3
    } state_t;

    typedef struct packed {
        logic [LEVEL_W-1:0] l;
        logic [LEVEL_W-1:0] r;
    } level_pair_t;

    // Frame check byte is the bitwise XOR of the two level bytes.
    function automatic logic [LEVEL_W-1:0] frame_chk(input logic [LEVEL_W-1:0] l,
                                                     input logic [LEVEL_W-1:0] r);
        return l ^ r;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge strobe on a level signal; the register resets high so a line that is
// already high at reset release never produces a strobe.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic stb_c
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign stb_c = level & ~level_q;

endmodule

// File: rtl/vu_frame_parser.sv
// Assembles SYNC/L/R/CHK frames from the UART byte stream and publishes checked
// stereo levels; bad checksums and inter-byte stalls are dropped and flagged.
module vu_frame_parser
    import vu_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC        = WIDTH'(SYNC_DEFAULT),
    parameter int unsigned      TIMEOUT_CYC = 48000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_dv,
    output logic [LEVEL_W-1:0] o_level_l,
    output logic [LEVEL_W-1:0] o_level_r,
    output logic               o_valid,
    output logic               o_err
);

    localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(TIMEOUT_CYC - 1);

    logic               stb_c;
    state_t             state_q, state_d;
    level_pair_t        hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEVEL_W-1:0] level_l_d, level_r_d;
    logic               valid_d, err_d;
    logic [LEVEL_W-1:0] byte_v;

    rise_detect u_rise (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .level (i_dv),
        .stb_c (stb_c)
    );

    // Frame FSM plus inter-byte watchdog; a strobe always beats the watchdog.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        level_l_d = o_level_l;
        level_r_d = o_level_r;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        byte_v    = LEVEL_W'(i_data);

        case (state_q)
            HUNT: begin
                cnt_d = '0;
                if (stb_c && (i_data == SYNC)) begin
                    state_d = GET_L;
                end
            end
            GET_L: begin
                if (stb_c) begin
                    hold_d.l = byte_v;
                    state_d  = GET_R;
                end
            end
            GET_R: begin
                if (stb_c) begin
                    hold_d.r = byte_v;
                    state_d  = GET_CHK;
                end
            end
            GET_CHK: begin
                if (stb_c) begin
                    if (byte_v == frame_chk(hold_q.l, hold_q.r)) begin
                        level_l_d = hold_q.l;
                        level_r_d = hold_q.r;
                        valid_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        if (state_q != HUNT) begin
            if (stb_c) begin
                cnt_d = '0;
            end else if (cnt_q == TERM) begin
                state_d = HUNT;
                err_d   = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= HUNT;
            hold_q    <= '0;
            cnt_q     <= '0;
            o_level_l <= '0;
            o_level_r <= '0;
            o_valid   <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            o_level_l <= level_l_d;
            o_level_r <= level_r_d;
            o_valid   <= valid_d;
            o_err     <= err_d;
        end
    end

endmodule

// File: doc/vu_frame_parser.md
# vu_frame_parser

Byte-stream frame parser sitting directly downstream of the UART receiver. It detects each completed byte from the receiver's data-valid line and assembles 4-byte frames (sync, left level, right level, checksum). Frames that pass the checksum drive the stereo level registers consumed by the VU meter display logic. Malformed or stalled frames are dropped and flagged.

## Interface
Parameters:
- WIDTH, 8, byte width; must match the receiver.
- SYNC, 8'hA5, frame start marker.
- TIMEOUT_CYC, 48000, inter-byte timeout in i_clk cycles (1 ms at 48 MHz); counter width $clog2(TIMEOUT_CYC).

Ports:
- i_clk  in  1  system clock, 48 MHz.
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_data  in  WIDTH  received byte; stable while i_dv is high.
- i_dv  in  1  receiver valid; low while a byte is in flight, high when idle; rising edge = new byte on i_data.
- o_level_l  out  8  last accepted left level.
- o_level_r  out  8  last accepted right level.
- o_valid  out  1  one-cycle pulse when o_level_l/o_level_r update.
- o_err  out  1  one-cycle pulse on checksum mismatch or timeout.

## Operation
- Reset values: o_level_l = 0, o_level_r = 0, o_valid = 0, o_err = 0, state HUNT, timeout counter 0, dv_q = 1 (no spurious strobe at reset release).
- Byte strobe: stb = i_dv & ~dv_q; dv_q is i_dv registered. i_data captured only when stb = 1.
- Frame: SYNC, L, R, C with C = L ^ R (bitwise XOR).
- States:
  - HUNT: stb with i_data == SYNC -> GET_L; any other byte discarded silently, no o_err.
  - GET_L: stb -> latch L into holding reg, -> GET_R. A SYNC value here is data, no resync.
  - GET_R: stb -> latch R, -> GET_CHK.
  - GET_CHK: stb -> if i_data == L ^ R: o_level_l <= L, o_level_r <= R, o_valid pulse; else o_err pulse, levels hold. Always -> HUNT.
- Timeout: in GET_L/GET_R/GET_CHK counter increments each cycle without stb, clears on stb; reaching TIMEOUT_CYC-1 -> HUNT, o_err pulse, counter 0. Counter held at 0 in HUNT.
- Simultaneous stb and timeout terminal count: stb wins, byte processed, no o_err.
- o_valid and o_err never high in the same cycle.
- Reset mid-frame: immediate return to reset values; partial frame discarded, levels cleared.

## Timing
- i_dv rising sampled at edge N -> stb high in cycle N; state, holding regs and outputs update at edge N+1.
- o_valid/o_err high exactly one cycle after the edge at which the CHK strobe is registered; deasserted the following cycle.
- Minimum byte spacing 2 cycles (i_dv must be low at least one sampled cycle between bytes); receiver guarantees ~4160 cycles at 115200 baud.
- Levels hold between valid frames; no output changes except on o_valid or reset.

## Structure
- Shared package vu_pkg: SYNC default, frame length constant (4), state encoding (HUNT, GET_L, GET_R, GET_CHK as 2-bit localparams), level width 8.
- One sub-module natural: rise_detect (dv_q register + stb output, reset value 1), reusable by other strobe consumers.
- Timeout counter and FSM stay in the top module.

## Test plan
- Valid frame A5, 40, C0, 80 (40^C0) -> o_valid one pulse, o_level_l=40, o_level_r=C0, o_err stays 0.
- Bad checksum A5, 10, 20, 00 -> o_err one pulse, o_valid 0, levels keep previous 40/C0.
- Garbage then frame: 00, FF, 12, A5, 01, 02, 03 -> no o_err for garbage, o_valid with levels 01/02.
- Stall: A5, 33 then no bytes -> o_err pulse exactly TIMEOUT_CYC cycles after 33 strobe, state HUNT; next full frame A5, 07, 09, 0E accepted.
- Reset: assert i_rst_n low after A5, 55 mid-frame -> outputs 0 immediately; after release, frame A5, 01, 01, 00 -> o_valid, levels 01/01; i_dv held high through reset release gives no strobe.
